rr_arbiter4: RTL and testbench
==============================

# rr_arbiter4

Four-requester round-robin arbiter that shares one resource, such as a decoded output bank or a shared bus, among requesters 0–3. It registers a one-hot grant by decoding a 2-bit owner index, the same 2-to-4 one-hot mapping the combinational decoder library uses. It enforces fairness with a rotating priority pointer and an optional maximum-hold timeout.

## Interface
Parameters:
- HOLD_MAX, 8: maximum consecutive granted cycles before forced rotation. 0 disables the timeout. Legal range 0–255.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- req  in  4  request vector; bit i is requester i. Level-sensitive, held high while the requester wants the resource.
- gnt  out  4  registered one-hot grant, or all-zero. gnt = 1 << gnt_idx when gnt_valid.
- gnt_idx  out  2  index of the current owner; holds the last owner when idle.
- gnt_valid  out  1  high when some requester holds the grant.
- timeout  out  1  one-cycle pulse on the edge where a grant is revoked by HOLD_MAX.

## Operation
- Internal state: FSM {IDLE, OWNED}, priority pointer ptr[1:0], hold counter cnt of 8 bits.
- Reset values: gnt=0000, gnt_idx=0, gnt_valid=0, timeout=0, ptr=0, cnt=0, state=IDLE.
- Selection function: scan req circularly starting at ptr (ptr, ptr+1, ptr+2, ptr+3 mod 4). The first set bit wins.
- IDLE: if req≠0, grant the selected index, set cnt=1, and go to OWNED. Otherwise stay idle with all outputs unchanged except gnt=0.
- OWNED, owner's req still high, and (HOLD_MAX=0 or cnt<HOLD_MAX): keep the grant and increment cnt. cnt saturates at 255.
- OWNED, owner's req low (release):
  - Set ptr=owner+1 mod 4.
  - If any other request is pending, grant the winner selected from the new ptr at the same edge, with no bubble, and set cnt=1.
  - Otherwise clear gnt, clear gnt_valid, and go to IDLE.
- OWNED, HOLD_MAX≠0, cnt=HOLD_MAX, owner still requesting (timeout):
  - Set ptr=owner+1 mod 4.
  - If another requester is pending, pulse timeout=1 and switch the grant to the winner selected from the new ptr, with cnt=1.
  - If none is pending, keep the same owner, reset cnt=1, and do not pulse timeout.
- The owner can never be re-selected over a pending requester immediately after a release or timeout, because ptr has moved past it.
- Requests appearing for a non-owner while OWNED have no effect until a release or timeout.
- gnt_idx and gnt always update together. gnt never has more than one bit set.

## Timing
- All outputs are registered and change only on the rising edge of clk or on rst_n assertion.
- Grant latency: a request sampled at edge k produces gnt visible after edge k.
- Release: the owner's req sampled low at edge k leads, after edge k, to either gnt=0 or the new owner's gnt.
- Simultaneous release and timeout at the same edge are treated as a release: no timeout pulse.
- With HOLD_MAX=N, a continuously requesting owner with a competitor holds exactly N cycles, then loses the grant.
- rst_n asserted mid-grant: all outputs go to reset values immediately and asynchronously. Deassertion is synchronous to clk. The first grant after reset scans from index 0.
- Throughput: one grant change per cycle maximum.

## Test plan
- Reset: hold rst_n=0 with req=1111, then drop rst_n mid-grant -> gnt=0000, gnt_valid=0, gnt_idx=0 asynchronously. After release, the first grant is gnt=0001.
- Single requester: req=0100 for 3 cycles, then 0000 -> gnt=0100, gnt_idx=2 for 3 cycles, then gnt=0000 and gnt_valid=0.
- Rotation with HOLD_MAX=0: req=1111, and each owner drops its bit for one cycle after 2 cycles -> grant order 0001, 0010, 0100, 1000, 0001, with no idle bubble between owners.
- Timeout with HOLD_MAX=3: req=0011 held constantly -> gnt=0001 for 3 cycles, timeout pulse, gnt=0010 for 3 cycles, pulse, 0001 again.
- Timeout with no competitor and HOLD_MAX=3: req=1000 for 10 cycles -> gnt=1000 throughout, timeout never asserts.
- Priority pointer: owner 3 releases while req=0101 -> next grant is 0001 (scan wraps from ptr=0), not 0100.

Source files
------------

// File: rtl/rr_arbiter4.sv
// rr_arbiter4 - four-requester round-robin arbiter with optional hold timeout.
//
// Grants one shared resource to requesters 0..3. The grant is registered as a
// one-hot vector decoded from a 2-bit owner index. Fairness comes from a
// rotating priority pointer that always moves past the previous owner, and an
// optional maximum-hold limit forces rotation when others are waiting.
//
// Parameters:
//   HOLD_MAX  maximum consecutive granted cycles before forced rotation
//             (0 disables the timeout, legal range 0..255)
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   req[3:0]   in   level-sensitive request vector, bit i = requester i
//   gnt[3:0]   out  registered one-hot grant (or all-zero when idle)
//   gnt_idx    out  current owner index, holds the last owner when idle
//   gnt_valid  out  high while some requester holds the grant
//   timeout    out  one-cycle pulse when HOLD_MAX revokes a grant
module rr_arbiter4 #(
  parameter int unsigned HOLD_MAX = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] gnt_idx,
  output logic       gnt_valid,
  output logic       timeout
);

  typedef enum logic {IDLE, OWNED} state_t;

  state_t      state_q;
  logic [1:0]  ptr_q;
  logic [1:0]  gnt_idx_q;
  logic [3:0]  gnt_q;
  logic        gnt_valid_q;
  logic        timeout_q;
  logic [7:0]  cnt_q;

  // Circular scan of r starting at p; returns {found, index}.
  // Iterating from the farthest offset down lets the nearest hit win.
  function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int k = 3; k >= 0; k--) begin
      idx = p + 2'(k);
      if (r[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  logic [1:0] next_ptr;
  logic [3:0] owner_mask;
  logic [2:0] pick_idle;
  logic [2:0] pick_rot;
  logic       owner_req;
  logic       hold_hit;

  always_comb begin
    next_ptr   = gnt_idx_q + 2'd1;
    owner_mask = 4'b0001 << gnt_idx_q;
    owner_req  = req[gnt_idx_q];
    pick_idle  = rr_pick(req, ptr_q);
    // Exclude the owner so a timeout only hands over to a real competitor.
    pick_rot   = rr_pick(req & ~owner_mask, next_ptr);
    hold_hit   = (HOLD_MAX != 0) && (cnt_q == 8'(HOLD_MAX));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= 2'd0;
      gnt_idx_q   <= 2'd0;
      gnt_q       <= 4'b0000;
      gnt_valid_q <= 1'b0;
      timeout_q   <= 1'b0;
      cnt_q       <= 8'd0;
    end else begin
      timeout_q <= 1'b0;
      case (state_q)
        IDLE: begin
          gnt_q <= 4'b0000;
          if (pick_idle[2]) begin
            gnt_idx_q   <= pick_idle[1:0];
            gnt_q       <= 4'b0001 << pick_idle[1:0];
            gnt_valid_q <= 1'b1;
            cnt_q       <= 8'd1;
            state_q     <= OWNED;
          end
        end
        OWNED: begin
          if (!owner_req) begin
            // Release takes precedence over a coincident timeout.
            ptr_q <= next_ptr;
            if (pick_rot[2]) begin
              gnt_idx_q <= pick_rot[1:0];
              gnt_q     <= 4'b0001 << pick_rot[1:0];
              cnt_q     <= 8'd1;
            end else begin
              gnt_q       <= 4'b0000;
              gnt_valid_q <= 1'b0;
              state_q     <= IDLE;
            end
          end else if (hold_hit) begin
            // Without a competitor the owner keeps the grant with a fresh count.
            ptr_q <= next_ptr;
            cnt_q <= 8'd1;
            if (pick_rot[2]) begin
              timeout_q <= 1'b1;
              gnt_idx_q <= pick_rot[1:0];
              gnt_q     <= 4'b0001 << pick_rot[1:0];
            end
          end else if (cnt_q != 8'hFF) begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign gnt       = gnt_q;
  assign gnt_idx   = gnt_idx_q;
  assign gnt_valid = gnt_valid_q;
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_rr_arbiter4.sv
// Directed testbench for rr_arbiter4. Three instances share clk and rst_n:
// A uses the default HOLD_MAX=8, B has the timeout disabled (HOLD_MAX=0),
// C uses HOLD_MAX=3. Inputs change and outputs are sampled on the falling edge.
module tb_rr_arbiter4;

  logic       clk;
  logic       rst_n;
  logic [3:0] req_a, req_b, req_c;
  logic [3:0] gnt_a, gnt_b, gnt_c;
  logic [1:0] idx_a, idx_b, idx_c;
  logic       val_a, val_b, val_c;
  logic       to_a, to_b, to_c;

  int n_checks = 0;
  int n_fail   = 0;

  rr_arbiter4 #(.HOLD_MAX(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .req(req_a),
    .gnt(gnt_a), .gnt_idx(idx_a), .gnt_valid(val_a), .timeout(to_a)
  );

  rr_arbiter4 #(.HOLD_MAX(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .req(req_b),
    .gnt(gnt_b), .gnt_idx(idx_b), .gnt_valid(val_b), .timeout(to_b)
  );

  rr_arbiter4 #(.HOLD_MAX(3)) dut_c (
    .clk(clk), .rst_n(rst_n), .req(req_c),
    .gnt(gnt_c), .gnt_idx(idx_c), .gnt_valid(val_c), .timeout(to_c)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic test_reset();
    rst_n = 1'b0; req_a = 4'b1111; req_b = 4'b0000; req_c = 4'b0000;
    @(negedge clk); @(negedge clk);
    n_checks++; if (gnt_a !== 4'b0000) begin n_fail++; $display("FAIL reset_gnt got=%b exp=0000", gnt_a); end
    n_checks++; if (val_a !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", val_a); end
    n_checks++; if (idx_a !== 2'd0) begin n_fail++; $display("FAIL reset_idx got=%0d exp=0", idx_a); end
    n_checks++; if (to_a !== 1'b0) begin n_fail++; $display("FAIL reset_timeout got=%b exp=0", to_a); end
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++; if (gnt_a !== 4'b0001) begin n_fail++; $display("FAIL first_grant got=%b exp=0001", gnt_a); end
    n_checks++; if (val_a !== 1'b1) begin n_fail++; $display("FAIL first_valid got=%b exp=1", val_a); end
    @(negedge clk);
    // Assert reset between edges: outputs must clear without a clock edge.
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (gnt_a !== 4'b0000) begin n_fail++; $display("FAIL async_reset_gnt got=%b exp=0000", gnt_a); end
    n_checks++; if (val_a !== 1'b0) begin n_fail++; $display("FAIL async_reset_valid got=%b exp=0", val_a); end
    n_checks++; if (idx_a !== 2'd0) begin n_fail++; $display("FAIL async_reset_idx got=%0d exp=0", idx_a); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++; if (gnt_a !== 4'b0001) begin n_fail++; $display("FAIL post_reset_grant got=%b exp=0001", gnt_a); end
    req_a = 4'b0000;
    @(negedge clk);
    n_checks++; if (val_a !== 1'b0) begin n_fail++; $display("FAIL reset_release_valid got=%b exp=0", val_a); end
    $display("test_reset done");
  endtask

  // dut_a is idle with ptr=1 on entry.
  task automatic test_single();
    req_a = 4'b0100;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++; if (gnt_a !== 4'b0100) begin n_fail++; $display("FAIL single_gnt cyc=%0d got=%b exp=0100", i, gnt_a); end
      n_checks++; if (idx_a !== 2'd2) begin n_fail++; $display("FAIL single_idx cyc=%0d got=%0d exp=2", i, idx_a); end
    end
    req_a = 4'b0000;
    @(negedge clk);
    n_checks++; if (gnt_a !== 4'b0000) begin n_fail++; $display("FAIL single_release_gnt got=%b exp=0000", gnt_a); end
    n_checks++; if (val_a !== 1'b0) begin n_fail++; $display("FAIL single_release_valid got=%b exp=0", val_a); end
    n_checks++; if (idx_a !== 2'd2) begin n_fail++; $display("FAIL single_idle_idx got=%0d exp=2", idx_a); end
    $display("test_single done");
  endtask

  // dut_a is idle with ptr=3 on entry.
  task automatic test_priority_pointer();
    req_a = 4'b1000;
    @(negedge clk);
    n_checks++; if (gnt_a !== 4'b1000) begin n_fail++; $display("FAIL ptr_owner3 got=%b exp=1000", gnt_a); end
    req_a = 4'b0101;
    @(negedge clk);
    n_checks++; if (gnt_a !== 4'b0001) begin n_fail++; $display("FAIL ptr_wrap got=%b exp=0001", gnt_a); end
    n_checks++; if (idx_a !== 2'd0) begin n_fail++; $display("FAIL ptr_wrap_idx got=%0d exp=0", idx_a); end
    req_a = 4'b0000;
    @(negedge clk);
    n_checks++; if (val_a !== 1'b0) begin n_fail++; $display("FAIL ptr_idle_valid got=%b exp=0", val_a); end
    $display("test_priority_pointer done");
  endtask

  // dut_b (HOLD_MAX=0) is idle with ptr=0 on entry.
  task automatic test_rotation();
    logic [3:0] exp_g;
    req_b = 4'b1111;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      exp_g = 4'b0001 << (i % 4);
      n_checks++; if (gnt_b !== exp_g) begin n_fail++; $display("FAIL rot_gnt step=%0d got=%b exp=%b", i, gnt_b, exp_g); end
      n_checks++; if (val_b !== 1'b1) begin n_fail++; $display("FAIL rot_valid step=%0d got=%b exp=1", i, val_b); end
      req_b = 4'b1111;
      @(negedge clk);
      n_checks++; if (gnt_b !== exp_g) begin n_fail++; $display("FAIL rot_hold step=%0d got=%b exp=%b", i, gnt_b, exp_g); end
      n_checks++; if (to_b !== 1'b0) begin n_fail++; $display("FAIL rot_timeout step=%0d got=%b exp=0", i, to_b); end
      req_b = 4'b1111 & ~exp_g;
      @(negedge clk);
      $display("rotation step %0d owner gnt=%b", i, exp_g);
    end
    req_b = 4'b0000;
    @(negedge clk);
    n_checks++; if (val_b !== 1'b0) begin n_fail++; $display("FAIL rot_idle_valid got=%b exp=0", val_b); end
    $display("test_rotation done");
  endtask

  // dut_c (HOLD_MAX=3) is idle with ptr=0 on entry.
  task automatic test_timeout();
    logic [3:0] exp_g  [7] = '{4'b0001, 4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0010, 4'b0001};
    logic       exp_to [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    req_c = 4'b0011;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      n_checks++; if (gnt_c !== exp_g[i]) begin n_fail++; $display("FAIL to_gnt cyc=%0d got=%b exp=%b", i, gnt_c, exp_g[i]); end
      n_checks++; if (to_c !== exp_to[i]) begin n_fail++; $display("FAIL to_pulse cyc=%0d got=%b exp=%b", i, to_c, exp_to[i]); end
    end
    req_c = 4'b0000;
    @(negedge clk);
    n_checks++; if (val_c !== 1'b0) begin n_fail++; $display("FAIL to_idle_valid got=%b exp=0", val_c); end
    $display("test_timeout done");
  endtask

  // dut_c is idle with ptr=1 on entry.
  task automatic test_timeout_alone();
    req_c = 4'b1000;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_checks++; if (gnt_c !== 4'b1000) begin n_fail++; $display("FAIL alone_gnt cyc=%0d got=%b exp=1000", i, gnt_c); end
      n_checks++; if (to_c !== 1'b0) begin n_fail++; $display("FAIL alone_timeout cyc=%0d got=%b exp=0", i, to_c); end
    end
    req_c = 4'b0000;
    @(negedge clk);
    n_checks++; if (val_c !== 1'b0) begin n_fail++; $display("FAIL alone_idle_valid got=%b exp=0", val_c); end
    $display("test_timeout_alone done");
  endtask

  // Owner releases on the same edge its hold limit is reached: plain release.
  // dut_c is idle with ptr=0 on entry.
  task automatic test_release_at_limit();
    req_c = 4'b0011;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++; if (gnt_c !== 4'b0001) begin n_fail++; $display("FAIL lim_gnt cyc=%0d got=%b exp=0001", i, gnt_c); end
    end
    req_c = 4'b0010;
    @(negedge clk);
    n_checks++; if (gnt_c !== 4'b0010) begin n_fail++; $display("FAIL lim_handover got=%b exp=0010", gnt_c); end
    n_checks++; if (to_c !== 1'b0) begin n_fail++; $display("FAIL lim_no_pulse got=%b exp=0", to_c); end
    req_c = 4'b0000;
    @(negedge clk);
    n_checks++; if (gnt_c !== 4'b0000) begin n_fail++; $display("FAIL lim_idle_gnt got=%b exp=0000", gnt_c); end
    $display("test_release_at_limit done");
  endtask

  initial begin
    test_reset();
    test_single();
    test_priority_pointer();
    test_rotation();
    test_timeout();
    test_timeout_alone();
    test_release_at_limit();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
